bus_select_decoder_5_32: RTL and testbench
==========================================

# bus_select_decoder_5_32

Registered 5-to-32 one-hot decoder that converts a 5-bit source code into the one-hot drive enable for the shared datapath bus. It is the inverse of the bus-select encoder. Each accepted request drives exactly one enable for a programmed number of cycles. A guaranteed dead interval follows every drive (break-before-make), so two sources never drive the bus at once. It sits between control-unit sequencing and the per-register/per-unit bus output gates.

## Interface
- N_SEL, 32: number of one-hot outputs; legal codes are 0..N_SEL-1 (N_SEL ≤ 32).
- SEL_W, 5: code width.
- HOLD_W, 4: width of the drive-length field.
- GAP_CYCLES, 1: dead cycles after each drive, before returning to IDLE (0 allowed).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_code  in  SEL_W  source code to decode.
- req_hold  in  HOLD_W  drive length in cycles; 0 treated as 1.
- out_en  out  N_SEL  one-hot bus drive enables; registered.
- busy  out  1  state ≠ IDLE.
- err  out  1  one-cycle pulse: request with code ≥ N_SEL was rejected.

## Operation
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - req_ready=1, out_en=0.
  - On req_valid at an edge with code < N_SEL: latch the code, load hold_cnt = max(req_hold,1), and go to DRIVE. out_en = 1<<code from that edge.
  - On req_valid with code ≥ N_SEL: err=1 for the next cycle, stay in IDLE, out_en stays 0, and the request is consumed.
- DRIVE:
  - out_en holds the latched one-hot value and hold_cnt decrements each edge.
  - When hold_cnt reaches 1 at an edge: out_en←0 and go to GAP, or to IDLE if GAP_CYCLES=0.
  - req_valid is ignored and req_ready=0.
- GAP: out_en=0. Count GAP_CYCLES edges, then go to IDLE.
- Invariants:
  - $onehot0(out_en) every cycle.
  - out_en never switches directly from one nonzero value to another.
  - The minimum zero interval between drives is GAP_CYCLES+1 cycles (GAP plus the IDLE accept cycle).
- req_code and req_hold are sampled only on the accept edge; later changes have no effect.
- Arithmetic: hold_cnt is HOLD_W bits and never wraps below 1. The gap counter is $clog2(GAP_CYCLES+1) bits, minimum 1 bit.

## Timing
- Reset (clr high at an edge):
  - Outputs: out_en=0, busy=0, err=0, req_ready=1 from the next cycle.
  - Internal: state=IDLE and both counters cleared.
  - clr has priority over all other inputs.
- Reset during DRIVE or GAP: out_en drops to 0 on that edge and the pending request is discarded.
- Accept at edge k: out_en is valid in cycles k+1 .. k+H, where H = max(req_hold,1); busy is high over the same span.
- out_en=0 in cycles k+H+1 .. k+H+GAP_CYCLES. The first cycle with req_ready=1 is k+H+GAP_CYCLES+1.
- The earliest next drive after an accept at edge k+H+GAP_CYCLES+1 therefore starts in cycle k+H+GAP_CYCLES+2.
- A rejected code produces err high in cycle k+1 only. req_ready stays 1, so back-to-back rejects produce consecutive err pulses.
- req_ready is a combinational decode of the state register. out_en, err and busy are direct register outputs.

## Structure
- Package bus_sel_pkg holds:
  - the state enum (IDLE, DRIVE, GAP);
  - default constants for N_SEL, SEL_W, HOLD_W and GAP_CYCLES.
- Sub-module decoder_5_32: purely combinational code→one-hot with an out-of-range flag. The top registers its output; all sequencing stays in the top-level FSM.

## Test plan
- Reset: clr high 2 cycles with req_valid=1 and code=3 → out_en=0, busy=0, err=0, req_ready=1; no drive occurs.
- Basic drive (GAP_CYCLES=1): code=5, hold=3 → out_en=32'h0000_0020 for exactly 3 cycles, then 0. req_ready is low for 4 cycles and high in the 5th.
- Zero hold: code=31, hold=0 → out_en=32'h8000_0000 for exactly 1 cycle.
- Back-to-back: req_valid held high with code 0/hold 2, then code 31/hold 1 → sequence 1,1,0,0,8000_0000. $onehot0 holds throughout and there is never a direct nonzero→nonzero transition.
- Illegal code (N_SEL=24 instance): code=24 → err=1 for one cycle, out_en stays 0, req_ready stays 1. Code 23 immediately after → out_en=24'h80_0000.
- Mid-drive reset: code=7, hold=8; assert clr in the 3rd drive cycle → out_en=0 the next cycle, state IDLE, and no residual drive or gap afterward.

Source files
------------

// File: rtl/bus_select_decoder_5_32_pkg.sv
// Shared types and default sizing for the bus-select decoder.
package bus_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_N_SEL      = 32;
    localparam int DEF_SEL_W      = 5;
    localparam int DEF_HOLD_W     = 4;
    localparam int DEF_GAP_CYCLES = 1;

endpackage

// File: rtl/bus_select_decoder_5_32_if.sv
// Request/drive bundle between control sequencing and the bus-select decoder.
interface bus_select_decoder_5_32_if
    import bus_sel_pkg::*;
#(
    parameter int N_SEL  = DEF_N_SEL,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int HOLD_W = DEF_HOLD_W
);
    logic              req_valid;
    logic              req_ready;
    logic [SEL_W-1:0]  req_code;
    logic [HOLD_W-1:0] req_hold;
    logic [N_SEL-1:0]  out_en;
    logic              busy;
    logic              err;

    modport master (
        output req_valid, req_code, req_hold,
        input  req_ready, out_en, busy, err
    );

    modport slave (
        input  req_valid, req_code, req_hold,
        output req_ready, out_en, busy, err
    );
endinterface

// File: rtl/bus_select_decoder_5_32_decoder.sv
// Combinational code to one-hot decode with an out-of-range flag.
module decoder_5_32
    import bus_sel_pkg::*;
#(
    parameter int N_SEL = DEF_N_SEL,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0] code,
    output logic [N_SEL-1:0] onehot,
    output logic             oor
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_SEL; i++) begin
            onehot[i] = (code == SEL_W'(i));
        end
    end

    assign oor = (32'(code) >= N_SEL);
endmodule

// File: rtl/bus_select_decoder_5_32.sv
// Registered one-hot bus drive enable with programmable hold and break-before-make gap.
module bus_select_decoder_5_32
    import bus_sel_pkg::*;
#(
    parameter int N_SEL      = DEF_N_SEL,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int HOLD_W     = DEF_HOLD_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                       clk,
    input  logic                       clr,
    bus_select_decoder_5_32_if.slave   bus
);
    localparam int GAP_W      = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [N_SEL-1:0]  out_en_q;
    logic              busy_q;
    logic              err_q;

    logic [N_SEL-1:0]  dec_onehot;
    logic              dec_oor;

    decoder_5_32 #(
        .N_SEL (N_SEL),
        .SEL_W (SEL_W)
    ) u_dec (
        .code   (bus.req_code),
        .onehot (dec_onehot),
        .oor    (dec_oor)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            out_en_q <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (dec_oor) begin
                            // Illegal codes are consumed with a one-cycle error pulse.
                            err_q <= 1'b1;
                        end else begin
                            state    <= DRIVE;
                            hold_cnt <= (bus.req_hold == '0) ? HOLD_W'(1) : bus.req_hold;
                            out_en_q <= dec_onehot;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (hold_cnt <= HOLD_W'(1)) begin
                        out_en_q <= '0;
                        gap_cnt  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST_I)) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    out_en_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.out_en    = out_en_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_select_decoder_5_32.sv
// Directed bench: a 32-output instance (GAP=1) and a 24-output instance for range checks.
module tb_bus_select_decoder_5_32;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bus_select_decoder_5_32_if #(.N_SEL(32), .SEL_W(5), .HOLD_W(4)) b32 ();
    bus_select_decoder_5_32_if #(.N_SEL(24), .SEL_W(5), .HOLD_W(4)) b24 ();

    bus_select_decoder_5_32 #(.N_SEL(32), .SEL_W(5), .HOLD_W(4), .GAP_CYCLES(1)) u32 (
        .clk (clk),
        .clr (clr),
        .bus (b32)
    );

    bus_select_decoder_5_32 #(.N_SEL(24), .SEL_W(5), .HOLD_W(4), .GAP_CYCLES(1)) u24 (
        .clk (clk),
        .clr (clr),
        .bus (b24)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        b32.req_valid = 1'b1; b32.req_code = 5'd3; b32.req_hold = 4'd2;
        b24.req_valid = 1'b1; b24.req_code = 5'd3; b24.req_hold = 4'd2;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (b32.out_en !== 32'h0 || b32.busy !== 1'b0 || b32.err !== 1'b0 || b32.req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset32 c%0d: out_en=%h busy=%b err=%b ready=%b, need 0/0/0/1",
                         c, b32.out_en, b32.busy, b32.err, b32.req_ready);
            end
            n_cmp++;
            if (b24.out_en !== 24'h0 || b24.busy !== 1'b0 || b24.req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset24 c%0d: out_en=%h busy=%b ready=%b", c, b24.out_en, b24.busy, b24.req_ready);
            end
        end
        b32.req_valid = 1'b0;
        b24.req_valid = 1'b0;
        clr = 1'b0;
        step();
        n_cmp++;
        if (b32.out_en !== 32'h0 || b32.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_after: out_en=%h ready=%b, need 0/1", b32.out_en, b32.req_ready);
        end
    endtask

    task automatic test_basic_drive();
        logic [31:0] exp_en [5] = '{32'h20, 32'h20, 32'h20, 32'h0, 32'h0};
        logic        exp_rdy[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        b32.req_valid = 1'b1; b32.req_code = 5'd5; b32.req_hold = 4'd3;
        for (int c = 0; c < 5; c++) begin
            step();
            b32.req_valid = 1'b0;
            b32.req_code  = 5'd9;
            n_cmp++;
            if (b32.out_en !== exp_en[c] || b32.req_ready !== exp_rdy[c]) begin
                n_bad++;
                $display("FAIL basic c%0d: out_en=%h ready=%b, need %h/%b",
                         c, b32.out_en, b32.req_ready, exp_en[c], exp_rdy[c]);
            end
            if (c < 3) begin
                n_cmp++;
                if (b32.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL basic_busy c%0d: busy=%b need 1", c, b32.busy);
                end
            end
        end
        n_cmp++;
        if (b32.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle_busy: busy=%b need 0", b32.busy);
        end
    endtask

    task automatic test_zero_hold();
        b32.req_valid = 1'b1; b32.req_code = 5'd31; b32.req_hold = 4'd0;
        step();
        b32.req_valid = 1'b0;
        n_cmp++;
        if (b32.out_en !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL zero_hold_on: out_en=%h need 80000000", b32.out_en);
        end
        step();
        n_cmp++;
        if (b32.out_en !== 32'h0 || b32.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_hold_gap: out_en=%h ready=%b need 0/0", b32.out_en, b32.req_ready);
        end
        step();
        n_cmp++;
        if (b32.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_hold_ready: ready=%b need 1", b32.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_en[6] = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h8000_0000, 32'h0};
        logic [31:0] prev = 32'h0;
        b32.req_valid = 1'b1; b32.req_code = 5'd0; b32.req_hold = 4'd2;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                b32.req_code = 5'd31; b32.req_hold = 4'd1;
            end
            if (c == 4) b32.req_valid = 1'b0;
            n_cmp++;
            if (b32.out_en !== exp_en[c]) begin
                n_bad++;
                $display("FAIL b2b c%0d: out_en=%h need %h", c, b32.out_en, exp_en[c]);
            end
            n_cmp++;
            if (!$onehot0(b32.out_en) || (prev != 0 && b32.out_en != 0 && b32.out_en != prev)) begin
                n_bad++;
                $display("FAIL b2b_onehot c%0d: out_en=%h prev=%h", c, b32.out_en, prev);
            end
            prev = b32.out_en;
        end
        step();
    endtask

    task automatic test_illegal_code();
        b24.req_valid = 1'b1; b24.req_code = 5'd24; b24.req_hold = 4'd1;
        step();
        n_cmp++;
        if (b24.err !== 1'b1 || b24.out_en !== 24'h0 || b24.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal24: err=%b out_en=%h ready=%b need 1/0/1", b24.err, b24.out_en, b24.req_ready);
        end
        b24.req_code = 5'd31;
        step();
        n_cmp++;
        if (b24.err !== 1'b1 || b24.out_en !== 24'h0) begin
            n_bad++;
            $display("FAIL illegal31: err=%b out_en=%h need 1/0", b24.err, b24.out_en);
        end
        b24.req_code = 5'd23;
        step();
        b24.req_valid = 1'b0;
        n_cmp++;
        if (b24.err !== 1'b0 || b24.out_en !== 24'h80_0000) begin
            n_bad++;
            $display("FAIL legal23: err=%b out_en=%h need 0/800000", b24.err, b24.out_en);
        end
        step();
        step();
        n_cmp++;
        if (b24.out_en !== 24'h0 || b24.req_ready !== 1'b1 || b24.err !== 1'b0) begin
            n_bad++;
            $display("FAIL legal23_done: out_en=%h ready=%b err=%b need 0/1/0", b24.out_en, b24.req_ready, b24.err);
        end
    endtask

    task automatic test_mid_reset();
        b32.req_valid = 1'b1; b32.req_code = 5'd7; b32.req_hold = 4'd8;
        step();
        // Valid stays up with a new code: it must be ignored while driving.
        b32.req_code = 5'd1;
        step();
        b32.req_valid = 1'b0;
        step();
        n_cmp++;
        if (b32.out_en !== 32'h80) begin
            n_bad++;
            $display("FAIL mid_drive: out_en=%h need 00000080", b32.out_en);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if (b32.out_en !== 32'h0 || b32.req_ready !== 1'b1 || b32.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: out_en=%h ready=%b busy=%b need 0/1/0", b32.out_en, b32.req_ready, b32.busy);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (b32.out_en !== 32'h0 || b32.req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL mid_reset_after c%0d: out_en=%h ready=%b need 0/1", c, b32.out_en, b32.req_ready);
            end
        end
    endtask

    initial begin
        b32.req_valid = 1'b0; b32.req_code = '0; b32.req_hold = '0;
        b24.req_valid = 1'b0; b24.req_code = '0; b24.req_hold = '0;
        #2;
        test_reset();
        test_basic_drive();
        test_zero_hold();
        test_back_to_back();
        test_illegal_code();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
